conv3x3_stream: RTL and testbench
=================================

# conv3x3_stream

Parametrised streaming 3x3 convolution engine with built-in zero padding, successor to the fixed top-level convolution engine. Accepts a raster-order pixel stream over a valid/ready handshake, keeps two line buffers, applies a runtime-loadable signed 3x3 kernel and emits one "same"-size result per input pixel. Sits between the pixel input stage and the result output mux of the convolution top level.

## Interface
- DATA_W, 8, unsigned pixel width
- COEF_W, 8, signed coefficient width
- IMG_W_MAX, 16, maximum image width (line-buffer depth)
- ACC_W, DATA_W+COEF_W+4, signed result width (9 products, no overflow)

- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- cfg_width  in  $clog2(IMG_W_MAX+1)  image width, sampled on first pixel of a frame
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  kernel index 0..8, row-major (4 = centre)
- coef_data  in  COEF_W  signed coefficient
- in_valid / in_ready  in / out  1  input handshake
- in_data  in  DATA_W  pixel
- in_last  in  1  last pixel of frame
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  ACC_W  result (signed, or clamped ≥0 with ReLU)
- out_last  out  1  last result of frame
- busy  out  1  high in STREAM or DRAIN
- err  out  1  sticky: in_last not at column W-1

## Operation
- Result(r,c) = Σ k[i][j]·p(r+i-1, c+j-1), i,j∈0..2; out-of-image pixels = 0 (masked by row/column counters, not by clearing RAM).
- States: IDLE → STREAM on first accepted pixel (latch W = clamp(cfg_width, 2, IMG_W_MAX)); STREAM → DRAIN on accepted in_last; DRAIN → IDLE after the frame's out_last handshake completes.
- DRAIN injects internal zero pixels (remainder of current row if short, then one padding row) one per cycle when output not stalled, until all rows·W results emitted.
- Coefficient writes honoured only in IDLE; ignored (no effect) in STREAM/DRAIN.
- in_ready = (state ∈ {IDLE, STREAM}) && (!out_valid || out_ready).
- Result count per frame = rows·W exactly; height is implicit from in_last; single-row frames legal.
- in_last at column ≠ W-1: err set, frame finished as if row padded with zeros.
- Arithmetic: pixel zero-extended, product signed, sum full ACC_W, no truncation.

## Timing
- Reset: out_valid=0, out_data=0, out_last=0, in_ready=0 during rst then 1 in IDLE, busy=0, err=0, state IDLE, counters 0, kernel = identity (k[4]=1, others 0).
- Result(r,c) becomes computable on acceptance of pixel index (r+1)·W+c+1 (or its drain equivalent); out_valid rises the following cycle. First result follows the (W+2)th accepted pixel.
- Single registered output stage; out_data/out_last held stable while out_valid && !out_ready.
- Throughput 1 pixel/cycle with out_ready high.
- Reset mid-frame: frame discarded, all outputs to reset values next cycle, kernel restored to identity.
- Simultaneous out handshake and input accept in same cycle is legal and required for full rate.

## Configuration
- CONV_RELU_EN defined: out_data = max(sum, 0).
- Undefined: out_data = raw signed sum.

## Structure
- Package conv_pkg: state enum (IDLE, STREAM, DRAIN), kernel index constants (K_CENTRE=4, K_TAPS=9), ACC_W derivation function.
- Sub-module line_buffer: IMG_W_MAX×DATA_W single-row delay, instantiated twice; top holds 3x3 window registers, counters, MAC and FSM.

## Test plan
- Identity kernel, W=4, 2x4 frame pixels 1..8 -> out 1..8, out_last with 8, err=0.
- All-ones kernel, W=3, 3x3 frame of 1s -> 4,6,4,6,9,6,4,6,4.
- Previous case with out_ready toggled 1010… -> identical sequence, no loss/duplication, in_ready low on stalled cycles.
- Write k[4]=5 during STREAM -> ignored, identity outputs continue; same write in IDLE -> next frame scaled ×5.
- k[4]=-1, pixel 5 at W=2, 1x2 frame -> out −5,−5 without CONV_RELU_EN; 0,0 with it.
- in_last at column 1 of W=4 -> err=1, 4 results emitted for that row; rst mid-frame -> busy=0, out_valid=0, kernel identity.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the streaming 3x3 convolution engine.
// Holds the FSM state enum, kernel tap indices and the result-width rule.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    localparam int K_CENTRE = 4;
    localparam int K_TAPS   = 9;

    // Nine products of DATA_W+COEF_W bits need four guard bits to never overflow.
    function automatic int acc_width(input int data_w, input int coef_w);
        return data_w + coef_w + 4;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-row pixel delay: read-before-write RAM indexed by the input column.
// Contents are never cleared; out-of-image taps are masked by the caller.
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 "same" convolution with zero padding and runtime kernel.
// Define CONV_RELU_EN to clamp results at zero; otherwise the raw signed sum is emitted.
//
// state  | meaning
// IDLE   | waiting for first pixel; kernel writable; width latched on accept
// STREAM | accepting frame pixels until in_last
// DRAIN  | injecting zero pixels until the frame's last result is taken
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int IMG_W_MAX = 16,
    parameter int ACC_W     = acc_width(DATA_W, COEF_W)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(IMG_W_MAX+1)-1:0] cfg_width,
    input  logic                           coef_we,
    input  logic [3:0]                     coef_addr,
    input  logic [COEF_W-1:0]              coef_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_W-1:0]               out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic                           err
);

    localparam int CW_W = $clog2(IMG_W_MAX + 1);
    localparam int AW   = $clog2(IMG_W_MAX);
    localparam logic [CW_W-1:0] W_MIN = CW_W'(2);
    localparam logic [CW_W-1:0] W_MAX = CW_W'(IMG_W_MAX);

    state_t state, state_nxt;
    logic [CW_W-1:0] w_q, w_cfg, w_cur, in_c, out_c;
    logic [1:0] row_cnt, drain_rows;
    logic drain_done, out_first_row;
    logic out_free, accept, inject, step, col_wrap, out_wrap, emit, final_px, frame_done;
    logic signed [COEF_W-1:0] kernel [K_TAPS];
    logic [DATA_W-1:0] win [2][3];
    logic [DATA_W-1:0] col_new [3];
    logic [DATA_W-1:0] tap [K_TAPS];
    logic [DATA_W-1:0] px_cur, lb1_q, lb2_q;
    logic signed [ACC_W-1:0] sum, res;

    always_comb begin
        w_cfg = cfg_width;
        if (cfg_width < W_MIN) w_cfg = W_MIN;
        else if (cfg_width > W_MAX) w_cfg = W_MAX;
    end

    assign w_cur      = (state == IDLE) ? w_cfg : w_q;
    assign out_free   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign inject     = (state == DRAIN) && out_free && !drain_done;
    assign step       = accept || inject;
    assign col_wrap   = (in_c == w_cur - CW_W'(1));
    assign out_wrap   = (out_c == w_cur - CW_W'(1));
    // Result (r,c) is complete once pixel (r+1,c+1) arrives, i.e. W+1 pixels later.
    assign emit       = (row_cnt == 2'd2) || (row_cnt == 2'd1 && in_c != '0);
    assign final_px   = inject && (drain_rows == 2'd2) && (in_c == '0);
    assign frame_done = (state == DRAIN) && out_valid && out_ready && out_last;
    assign px_cur     = (state == DRAIN) ? '0 : in_data;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_last ? DRAIN : STREAM;
            STREAM:  if (accept && in_last) state_nxt = DRAIN;
            DRAIN:   if (frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = !rst && (state == IDLE || state == STREAM) && out_free;
        busy     = (state != IDLE);
    end

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W_MAX)) u_lb1 (
        .clk(clk), .en(step), .addr(in_c[AW-1:0]), .din(px_cur), .dout(lb1_q)
    );

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W_MAX)) u_lb2 (
        .clk(clk), .en(step), .addr(in_c[AW-1:0]), .din(lb1_q), .dout(lb2_q)
    );

    always_comb begin
        col_new[0] = lb2_q;
        col_new[1] = lb1_q;
        col_new[2] = px_cur;
    end

    // Window taps in kernel order; taps outside the image are forced to zero.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                tap[i*3+j] = (j == 2) ? col_new[i] : win[j][i];
                if ((i == 0 && out_first_row) || (j == 0 && out_c == '0) || (j == 2 && out_wrap))
                    tap[i*3+j] = '0;
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int t = 0; t < K_TAPS; t++) begin
            sum = sum + ACC_W'($signed({1'b0, tap[t]})) * ACC_W'(kernel[t]);
        end
`ifdef CONV_RELU_EN
        res = sum[ACC_W-1] ? '0 : sum;
`else
        res = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < K_TAPS; t++) begin
                if (t == K_CENTRE) kernel[t] <= COEF_W'(1);
                else               kernel[t] <= '0;
            end
        end else if (coef_we && state == IDLE && coef_addr < 4'(K_TAPS)) begin
            kernel[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q           <= W_MIN;
            in_c          <= '0;
            out_c         <= '0;
            row_cnt       <= '0;
            drain_rows    <= '0;
            drain_done    <= 1'b0;
            out_first_row <= 1'b1;
            err           <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            for (int j = 0; j < 2; j++)
                for (int i = 0; i < 3; i++)
                    win[j][i] <= '0;
        end else begin
            if (state == IDLE && accept) w_q <= w_cfg;
            if (accept && in_last && !col_wrap) err <= 1'b1;
            if (step) begin
                in_c <= col_wrap ? '0 : in_c + CW_W'(1);
                if (col_wrap && row_cnt != 2'd2) row_cnt <= row_cnt + 2'd1;
                if (accept && in_last) drain_rows <= {1'b0, col_wrap};
                else if (inject && col_wrap) drain_rows <= drain_rows + 2'd1;
                if (final_px) drain_done <= 1'b1;
                win[0]    <= win[1];
                win[1]    <= col_new;
                out_valid <= emit;
                out_data  <= res;
                out_last  <= final_px;
                if (emit) begin
                    out_c <= out_wrap ? '0 : out_c + CW_W'(1);
                    if (out_wrap) out_first_row <= 1'b0;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (frame_done) begin
                in_c          <= '0;
                out_c         <= '0;
                row_cnt       <= '0;
                drain_rows    <= '0;
                drain_done    <= 1'b0;
                out_first_row <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream: hand-computed frames, stalls, kernel writes,
// error flag and mid-frame reset.
module tb_conv3x3_stream;

    localparam int DATA_W    = 8;
    localparam int COEF_W    = 8;
    localparam int IMG_W_MAX = 16;
    localparam int ACC_W     = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [4:0]        cfg_width = 5'd4;
    logic              coef_we = 1'b0;
    logic [3:0]        coef_addr = '0;
    logic [COEF_W-1:0] coef_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  out_data;
    logic              out_last;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    conv3x3_stream #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .IMG_W_MAX(IMG_W_MAX), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_width(cfg_width),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pix_q[$];
    int exp_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_coef(input int addr, input int val);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 4'(addr);
        coef_data = COEF_W'(val);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    // Streams pix_q and compares the collected results against exp_q.
    task automatic run_frame(input int w, input string tag, input bit toggle, input bit poke);
        int idx = 0;
        int cyc = 0;
        int lastpos = -1;
        bit done = 1'b0;
        int got[$];
        cfg_width = 5'(w);
        while (!done && cyc < 400) begin
            @(negedge clk);
            in_valid  = (idx < pix_q.size());
            in_data   = in_valid ? DATA_W'(pix_q[idx]) : '0;
            in_last   = in_valid && (idx == pix_q.size() - 1);
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            coef_we   = poke && (idx == 1);
            coef_addr = 4'd4;
            coef_data = COEF_W'(5);
            #1;
            if (out_valid && !out_ready) check({tag, " stall in_ready"}, int'(in_ready), 0);
            if (out_valid && out_ready) begin
                got.push_back(int'($signed(out_data)));
                if (out_last) begin
                    lastpos = got.size() - 1;
                    done = 1'b1;
                end
            end
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        coef_we   = 1'b0;
        out_ready = 1'b1;
        #1;
        check({tag, " finished"}, int'(done), 1);
        check({tag, " count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check($sformatf("%s res[%0d]", tag, i), got[i], exp_q[i]);
        end
        check({tag, " last pos"}, lastpos, exp_q.size() - 1);
        check({tag, " busy after"}, int'(busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_data", int'(out_data), 0);
        check("rst out_last", int'(out_last), 0);
        check("rst busy", int'(busy), 0);
        check("rst err", int'(err), 0);
        check("idle in_ready", int'(in_ready), 1);

        pix_q = {1, 2, 3, 4, 5, 6, 7, 8};
        exp_q = {1, 2, 3, 4, 5, 6, 7, 8};
        run_frame(4, "ident", 1'b0, 1'b0);
        check("ident err", int'(err), 0);

        for (int a = 0; a < 9; a++) write_coef(a, 1);
        pix_q = {1, 1, 1, 1, 1, 1, 1, 1, 1};
        exp_q = {4, 6, 4, 6, 9, 6, 4, 6, 4};
        run_frame(3, "ones", 1'b0, 1'b0);
        run_frame(3, "ones stall", 1'b1, 1'b0);

        for (int a = 0; a < 9; a++) write_coef(a, (a == 4) ? 1 : 0);
        pix_q = {1, 2, 3, 4};
        exp_q = {1, 2, 3, 4};
        run_frame(2, "busy write", 1'b0, 1'b1);
        write_coef(4, 5);
        exp_q = {5, 10, 15, 20};
        run_frame(2, "idle write", 1'b0, 1'b0);

        write_coef(4, -1);
        pix_q = {5, 5};
`ifdef CONV_RELU_EN
        exp_q = {0, 0};
`else
        exp_q = {-5, -5};
`endif
        run_frame(2, "neg", 1'b0, 1'b0);

        write_coef(4, 1);
        pix_q = {1, 2};
        exp_q = {1, 2, 0, 0};
        run_frame(4, "short row", 1'b0, 1'b0);
        check("short row err", int'(err), 1);

        write_coef(4, 3);
        cfg_width = 5'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DATA_W'(i + 1);
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid busy before rst", int'(busy), 1);
        @(negedge clk);
        #1;
        check("mid rst busy", int'(busy), 0);
        check("mid rst out_valid", int'(out_valid), 0);
        check("mid rst out_last", int'(out_last), 0);
        check("mid rst out_data", int'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid rst err", int'(err), 0);
        check("mid rst in_ready", int'(in_ready), 1);
        pix_q = {7, 8};
        exp_q = {7, 8};
        run_frame(2, "after rst", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
